config_frame_loader: RTL

// - Upstream feeder of the fabric configuration latch array. Consumes a 32-bit bitstream

---
 rtl/cfg_loader_pkg.sv | 29 ++
 rtl/config_frame_loader_if.sv | 11 +
 rtl/frame_strobe_gen.sv | 41 ++++
 rtl/config_frame_loader.sv | 119 +++++++++++
 4 files changed

// File: rtl/cfg_loader_pkg.sv
// Shared state encoding, header field layout and defaults for the configuration frame loader.
package cfg_loader_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned FIELD_W = 8;
  localparam int unsigned END_BIT = 31;
  localparam int unsigned COL_MSB = 23;
  localparam int unsigned COL_LSB = 16;
  localparam int unsigned FRM_MSB = 7;
  localparam int unsigned FRM_LSB = 0;

  localparam logic [WORD_W-1:0] SYNC_WORD_DEF = 32'hFAB0_FAB1;

  typedef enum logic [2:0] {
    HUNT,
    HEADER,
    DATA,
    SETUP,
    PULSE,
    HOLD,
    SKIP
  } state_t;

  // States in which the loader takes a word from the stream.
  function automatic logic is_accepting(input state_t s);
    return (s == HUNT) || (s == HEADER) || (s == DATA) || (s == SKIP);
  endfunction

endpackage

// File: rtl/config_frame_loader_if.sv
// Bitstream word stream: valid/ready handshake carrying one 32-bit word per transfer.
interface config_frame_loader_if;

  logic [cfg_loader_pkg::WORD_W-1:0] s_data;
  logic                              s_valid;
  logic                              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/frame_strobe_gen.sv
// Registered binary-to-one-hot latch enable generator; holds the strobe for PULSE_CYCLES clocks.
module frame_strobe_gen #(
  parameter int unsigned MAX_FRAMES   = 20,
  parameter int unsigned PULSE_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [$clog2(MAX_FRAMES)-1:0] frame,
  output logic [MAX_FRAMES-1:0]         strobe,
  output logic                          last_c
);

  localparam int unsigned CNT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;
  logic             active;

  assign last_c = active && (cnt == '0);

  // Async clear drops the enable immediately, even mid-pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      strobe <= MAX_FRAMES'(1) << frame;
      cnt    <= CNT_W'(PULSE_CYCLES - 1);
      active <= 1'b1;
    end else if (active) begin
      if (cnt == '0) begin
        strobe <= '0;
        active <= 1'b0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/config_frame_loader.sv
// Bitstream front end: locks on the sync word, decodes frame headers and sequences
// setup/pulse/hold around a one-hot latch enable per frame row.
module config_frame_loader
  import cfg_loader_pkg::*;
#(
  parameter int unsigned       FRAME_BITS   = 32,
  parameter int unsigned       MAX_FRAMES   = 20,
  parameter int unsigned       NUM_COLUMNS  = 16,
  parameter logic [WORD_W-1:0] SYNC_WORD    = SYNC_WORD_DEF,
  parameter int unsigned       PULSE_CYCLES = 1
) (
  input  logic                           CLK,
  input  logic                           resetn,
  config_frame_loader_if.slave           s,
  output logic [FRAME_BITS-1:0]          frame_data,
  output logic [$clog2(NUM_COLUMNS)-1:0] frame_col,
  output logic [MAX_FRAMES-1:0]          frame_strobe,
  output logic                           config_active,
  output logic                           cfg_err
);

  localparam int unsigned COL_W = $clog2(NUM_COLUMNS);
  localparam int unsigned FRM_W = $clog2(MAX_FRAMES);

  state_t             state;
  state_t             state_nx;
  logic               ready_q;
  logic [COL_W-1:0]   pend_col;
  logic [FRM_W-1:0]   pend_frame;
  logic               accept_c;
  logic [FIELD_W-1:0] hdr_col_c;
  logic [FIELD_W-1:0] hdr_frm_c;
  logic               hdr_end_c;
  logic               hdr_bad_c;
  logic               strobe_start_c;
  logic               pulse_last_c;

  assign s.s_ready      = ready_q;
  assign accept_c       = s.s_valid && ready_q;
  assign hdr_end_c      = s.s_data[END_BIT];
  assign hdr_col_c      = s.s_data[COL_MSB:COL_LSB];
  assign hdr_frm_c      = s.s_data[FRM_MSB:FRM_LSB];
  assign hdr_bad_c      = (hdr_col_c >= FIELD_W'(NUM_COLUMNS)) ||
                          (hdr_frm_c >= FIELD_W'(MAX_FRAMES));
  assign strobe_start_c = (state == SETUP);

  // Next state; the strobe phases advance unconditionally, accepting states wait on valid.
  always_comb begin
    state_nx = state;
    case (state)
      HUNT:   if (accept_c && (s.s_data == SYNC_WORD)) state_nx = HEADER;
      HEADER: begin
        if (accept_c) begin
          if (hdr_end_c)      state_nx = HUNT;
          else if (hdr_bad_c) state_nx = SKIP;
          else                state_nx = DATA;
        end
      end
      DATA:   if (accept_c) state_nx = SETUP;
      SETUP:  state_nx = PULSE;
      PULSE:  if (pulse_last_c) state_nx = HOLD;
      HOLD:   state_nx = HEADER;
      SKIP:   if (accept_c) state_nx = HEADER;
      default: state_nx = HUNT;
    endcase
  end

  // State and registered outputs; frame_data/frame_col move only on a data accept.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state         <= HUNT;
      ready_q       <= 1'b0;
      pend_col      <= '0;
      pend_frame    <= '0;
      frame_data    <= '0;
      frame_col     <= '0;
      config_active <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      state   <= state_nx;
      ready_q <= is_accepting(state_nx);
      case (state)
        HUNT: if (accept_c && (s.s_data == SYNC_WORD)) config_active <= 1'b1;
        HEADER: begin
          if (accept_c) begin
            if (hdr_end_c) begin
              config_active <= 1'b0;
            end else if (hdr_bad_c) begin
              cfg_err <= 1'b1;
            end else begin
              pend_col   <= COL_W'(hdr_col_c);
              pend_frame <= FRM_W'(hdr_frm_c);
            end
          end
        end
        DATA: begin
          if (accept_c) begin
            frame_data <= FRAME_BITS'(s.s_data);
            frame_col  <= pend_col;
          end
        end
        default: ;
      endcase
    end
  end

  frame_strobe_gen #(
    .MAX_FRAMES   (MAX_FRAMES),
    .PULSE_CYCLES (PULSE_CYCLES)
  ) u_strobe_gen (
    .clk    (CLK),
    .rst_n  (resetn),
    .start  (strobe_start_c),
    .frame  (pend_frame),
    .strobe (frame_strobe),
    .last_c (pulse_last_c)
  );

endmodule
